qr_row_sched: RTL and testbench
===============================

# qr_row_sched

Sequencer for one row of the Givens-rotation QR systolic array: one GG cell in column 0, feeding N_COL-1 GR cells through the d_i rotation-direction chain. The block accepts matrix rows from a host over a valid/ready handshake and skews the columns so each cell sees its operand one cycle after its left neighbour. It flags the first row so cells load rather than rotate, paces rows to the CORDIC iteration count, and captures the finished R row for the host. It sits between the matrix-row source and the GG/GR cell row.

## Interface
- DATA_WIDTH, 20: fixed-point (20,10) operand width.
- N_COL, 4: columns in the array (cell 0 = GG, cells 1..N_COL-1 = GR); ≥2.
- N_ROW, 8: matrix rows per decomposition; ≥1.
- ITER, 12: cycles a cell is busy per rotation; ≥N_COL.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: begin a decomposition; sampled only in IDLE.
- in_valid, in, 1: host row valid.
- in_ready, out, 1: block accepts row.
- in_row, in, N_COL*DATA_WIDTH: row; column j at bits [j*DATA_WIDTH +: DATA_WIDTH].
- cell_a, out, N_COL*DATA_WIDTH: per-column operand to cells, same packing.
- cell_vld, out, N_COL: one-cycle strobe per column; operand valid.
- cell_init, out, N_COL: first-row flag, aligned with cell_vld.
- r_in, in, N_COL*DATA_WIDTH: cells' rij_ff_o, packed.
- r_out, out, N_COL*DATA_WIDTH: captured R row.
- r_valid, out, 1; r_ready, in, 1: result handshake.
- busy, out, 1: high in any state except IDLE.
- done, out, 1: one-cycle pulse when the result handshake completes.

## Operation
- States: IDLE, FEED, FLUSH, OUT.
- IDLE: outputs idle. On start, go to FEED; row_cnt=0, phase_cnt=0, in_ready=1.
- FEED: on in_valid&&in_ready, latch in_row into the skew registers and drop in_ready. phase_cnt counts 1..ITER. in_ready re-asserts when phase_cnt reaches ITER. row_cnt increments per accepted row. After the row with row_cnt==N_ROW-1 is accepted, go to FLUSH, with in_ready held 0.
- Skew: column j register is loaded at its own strobe cycle and holds until that column's next strobe. Older column data is never overwritten early.
- cell_init[j]=1 only with the cell_vld[j] strobe of row 0.
- FLUSH: wait until the last column's strobe plus ITER cycles have elapsed. Then capture r_in into r_out and set r_valid. Go to OUT.
- OUT: hold r_out and r_valid until r_ready. In the handshake cycle, clear r_valid, pulse done next cycle, and return to IDLE.
- start is ignored outside IDLE. in_valid is ignored while in_ready=0; the host holds in_row stable.
- Counter widths: phase_cnt $clog2(ITER+N_COL), row_cnt $clog2(N_ROW+1). Neither counter wraps: both reset at start.
- No arithmetic on data; operands pass through bit-exact.

## Timing
- Reset: in_ready, cell_vld, cell_init, r_valid, busy, done = 0; cell_a, r_out = 0; state IDLE. Reset mid-operation aborts immediately with no done pulse.
- start at cycle s: busy=1 and in_ready=1 at s+1.
- Row accepted at cycle t: in_ready=0 at t+1. cell_vld[j] and cell_a column j update at t+1+j. in_ready=1 again at t+ITER, so the minimum row period is ITER cycles.
- Last row accepted at T: cell_vld[N_COL-1] at T+N_COL. r_valid=1 at T+N_COL+ITER+1.
- r_ready in the same cycle r_valid rises completes the transfer that cycle. done is at the next cycle; busy=0 with done.
- Back-to-back: start is accepted in the cycle after done.

## Configuration
- QR_ROW_SCHED_PERF_EN defined: adds output cyc_cnt (32-bit). It counts cycles from start to done, freezes at done, and clears at the next start. It saturates at all-ones.
- QR_ROW_SCHED_PERF_EN undefined: no port and no logic.

## Structure
- Shared package qr_pkg: DATA_WIDTH/D_WIDTH defaults, the state enum, the column-slice helper, and fixed-point constants.
- One sub-module, qr_skew_line: per-column delay/hold register chain generating cell_a, cell_vld and cell_init from the latched row and a strobe. The controller FSM and counters stay in qr_row_sched.

## Test plan
- Reset mid-FEED (rst at row 3) -> all outputs 0 next cycle; no done; a fresh start runs normally.
- N_COL=2, N_ROW=1, ITER=12: start, then row {col0=0x02400 (9.0), col1=0xFAC00 (-21.0)} accepted at t. Expected:
  - cell_vld[0] and cell_init[0] at t+1; cell_vld[1] and cell_init[1] at t+2;
  - r_valid at t+15, r_out=r_in.
- N_ROW=2, in_valid held high: second accept exactly 12 cycles after the first; cell_init=0 on row 1 strobes; column 0 data does not change before its strobe.
- r_ready held low 20 cycles -> r_out and r_valid stable; done only after r_ready.
- start pulsed during FEED and OUT -> no effect; in_valid while in_ready=0 -> row not consumed, row_cnt unchanged.
- With QR_ROW_SCHED_PERF_EN, N_COL=2, N_ROW=1, ITER=12, row presented at start+1, r_ready held high -> cyc_cnt=17 at done.

Source files
------------

// File: rtl/qr_pkg.sv
// Shared definitions for the QR row scheduler: default operand width,
// controller state encoding, packed-row column helper and fixed-point
// constants for the (20,10) operand format.
package qr_pkg;

  localparam int DATA_WIDTH = 20;
  localparam int D_WIDTH    = DATA_WIDTH;
  localparam int FRAC_BITS  = 10;

  localparam logic [D_WIDTH-1:0] FP_ONE  = D_WIDTH'(1 << FRAC_BITS);
  localparam logic [D_WIDTH-1:0] FP_ZERO = '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_FLUSH = 2'd2,
    S_OUT   = 2'd3
  } sched_state_t;

  // LSB position of column col in a row packed as col*width
  function automatic int col_lsb(input int col, input int width);
    return col * width;
  endfunction

endpackage

// File: rtl/qr_skew_line.sv
// Column skew for one systolic row. An accepted row lands in column 0 on
// the cycle after acceptance; each further column is loaded one cycle after
// its left neighbour. Every column register holds until its own next strobe,
// so a cell never sees its operand change early.
module qr_skew_line #(
  parameter int DATA_WIDTH = 20,
  parameter int N_COL      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic                        load_init,
  input  logic [N_COL*DATA_WIDTH-1:0] row_in,
  output logic [N_COL*DATA_WIDTH-1:0] cell_a,
  output logic [N_COL-1:0]            cell_vld,
  output logic [N_COL-1:0]            cell_init
);
  import qr_pkg::*;

  // Columns 1..N_COL-1 are consumed later than the accept cycle, so keep a
  // copy of them (and the first-row flag) until the next accepted row.
  logic [(N_COL-1)*DATA_WIDTH-1:0] row_lat;
  logic                            init_lat;

  // latch the upper columns and the first-row flag on every accepted row
  always_ff @(posedge clk) begin
    if (rst) begin
      row_lat  <= '0;
      init_lat <= 1'b0;
    end else if (load) begin
      row_lat  <= row_in[N_COL*DATA_WIDTH-1:DATA_WIDTH];
      init_lat <= load_init;
    end
  end

  for (genvar j = 0; j < N_COL; j++) begin : g_col
    logic                  fire;
    logic                  init_src;
    logic [DATA_WIDTH-1:0] src;
    logic [DATA_WIDTH-1:0] a_q;
    logic                  vld_q;
    logic                  init_q;

    if (j == 0) begin : g_head
      assign fire     = load;
      assign init_src = load_init;
      assign src      = row_in[col_lsb(0, DATA_WIDTH) +: DATA_WIDTH];
    end else begin : g_tail
      assign fire     = cell_vld[j-1];
      assign init_src = init_lat;
      assign src      = row_lat[col_lsb(j-1, DATA_WIDTH) +: DATA_WIDTH];
    end

    // per-column operand register with its one-cycle strobe and first-row flag
    always_ff @(posedge clk) begin
      if (rst) begin
        a_q    <= '0;
        vld_q  <= 1'b0;
        init_q <= 1'b0;
      end else begin
        vld_q  <= fire;
        init_q <= fire & init_src;
        if (fire) begin
          a_q <= src;
        end
      end
    end

    assign cell_a[col_lsb(j, DATA_WIDTH) +: DATA_WIDTH] = a_q;
    assign cell_vld[j]  = vld_q;
    assign cell_init[j] = init_q;
  end

endmodule

// File: rtl/qr_row_sched.sv
// Row sequencer for one Givens-rotation QR systolic row (GG cell + GR cells).
// Accepts N_ROW host rows paced ITER cycles apart, skews them across the
// cells, waits for the last column to finish rotating, then hands the R row
// to the host.
//
// Optional feature: define QR_ROW_SCHED_PERF_EN to add a 32-bit saturating
// cycle counter output (cyc_cnt) covering start to done.
//
// state   | meaning
// S_IDLE  | waiting for start, outputs idle
// S_FEED  | accepting rows, one per ITER cycles
// S_FLUSH | last row in flight, waiting for last column + ITER
// S_OUT   | R row presented, waiting for r_ready
module qr_row_sched #(
  parameter int DATA_WIDTH = qr_pkg::D_WIDTH,
  parameter int N_COL      = 4,
  parameter int N_ROW      = 8,
  parameter int ITER       = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_COL*DATA_WIDTH-1:0] in_row,
  output logic [N_COL*DATA_WIDTH-1:0] cell_a,
  output logic [N_COL-1:0]            cell_vld,
  output logic [N_COL-1:0]            cell_init,
  input  logic [N_COL*DATA_WIDTH-1:0] r_in,
  output logic [N_COL*DATA_WIDTH-1:0] r_out,
  output logic                        r_valid,
  input  logic                        r_ready,
  output logic                        busy,
  output logic                        done
`ifdef QR_ROW_SCHED_PERF_EN
  ,
  output logic [31:0]                 cyc_cnt
`endif
);
  import qr_pkg::*;

  localparam int PH_W = $clog2(ITER + N_COL);
  localparam int RC_W = $clog2(N_ROW + 1);

  localparam logic [PH_W-1:0] PH_ITER  = PH_W'(ITER);
  // In FLUSH the phase counter restarts at 0 on the cycle after the last
  // accept, so this value marks the last column's strobe plus ITER cycles.
  localparam logic [PH_W-1:0] PH_FLUSH = PH_W'(ITER + N_COL - 1);
  localparam logic [RC_W-1:0] LAST_ROW = RC_W'(N_ROW - 1);

  sched_state_t    state_q;
  sched_state_t    state_d;
  logic [PH_W-1:0] phase_cnt;
  logic [RC_W-1:0] row_cnt;

  logic start_go;
  logic accept;
  logic last_accept;
  logic flush_end;
  logic r_xfer;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state decode and handshake outputs
  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    busy        = (state_q != S_IDLE);
    r_valid     = (state_q == S_OUT);
    start_go    = 1'b0;
    accept      = 1'b0;
    last_accept = 1'b0;
    flush_end   = 1'b0;
    r_xfer      = 1'b0;
    case (state_q)
      S_IDLE: begin
        start_go = start;
        if (start) begin
          state_d = S_FEED;
        end
      end
      S_FEED: begin
        in_ready    = (phase_cnt == '0) || (phase_cnt == PH_ITER);
        accept      = in_ready && in_valid;
        last_accept = accept && (row_cnt == LAST_ROW);
        if (last_accept) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        flush_end = (phase_cnt == PH_FLUSH);
        if (flush_end) begin
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        r_xfer = r_ready;
        if (r_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // row pacing and row count; both restart at every start
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_cnt <= '0;
      row_cnt   <= '0;
    end else if (start_go) begin
      phase_cnt <= '0;
      row_cnt   <= '0;
    end else if (accept) begin
      row_cnt   <= row_cnt + RC_W'(1);
      phase_cnt <= last_accept ? '0 : PH_W'(1);
    end else if ((state_q == S_FEED) && (phase_cnt != '0) && (phase_cnt != PH_ITER)) begin
      phase_cnt <= phase_cnt + PH_W'(1);
    end else if ((state_q == S_FLUSH) && !flush_end) begin
      phase_cnt <= phase_cnt + PH_W'(1);
    end
  end

  // result capture and completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
      done  <= 1'b0;
    end else begin
      done <= r_xfer;
      if (flush_end) begin
        r_out <= r_in;
      end
    end
  end

`ifdef QR_ROW_SCHED_PERF_EN
  // start-to-done cycle count, saturating, frozen while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt <= '0;
    end else if (start_go) begin
      cyc_cnt <= 32'd1;
    end else if (busy && (cyc_cnt != '1)) begin
      cyc_cnt <= cyc_cnt + 32'd1;
    end
  end
`endif

  qr_skew_line #(
    .DATA_WIDTH(DATA_WIDTH),
    .N_COL     (N_COL)
  ) u_skew (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_init(row_cnt == '0),
    .row_in   (in_row),
    .cell_a   (cell_a),
    .cell_vld (cell_vld),
    .cell_init(cell_init)
  );

endmodule

// File: tb/tb_qr_row_sched.sv
// Bench for qr_row_sched. Instance u_a (2 columns, 1 row) runs the worked
// example and the result-hold sequence; instance u_b (4 columns, 4 rows) runs
// the held-valid, mid-FEED reset and random traffic against a timeline model.
module tb_qr_row_sched;
  localparam int DW  = 20;
  localparam int IT  = 12;
  localparam int NCA = 2;
  localparam int NRA = 1;
  localparam int NCB = 4;
  localparam int NRB = 4;
  localparam int BW  = 4 + 2*NCB + 2*NCB*DW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             start_a, in_valid_a, in_ready_a, r_valid_a, r_ready_a, busy_a, done_a;
  logic [NCA*DW-1:0] in_row_a, cell_a_a, r_in_a, r_out_a;
  logic [NCA-1:0]    cell_vld_a, cell_init_a;

  logic             start_b, in_valid_b, in_ready_b, r_valid_b, r_ready_b, busy_b, done_b;
  logic [NCB*DW-1:0] in_row_b, cell_a_b, r_in_b, r_out_b;
  logic [NCB-1:0]    cell_vld_b, cell_init_b;

`ifdef QR_ROW_SCHED_PERF_EN
  logic [31:0] cyc_cnt_a, cyc_cnt_b;
`endif

  qr_row_sched #(.DATA_WIDTH(DW), .N_COL(NCA), .N_ROW(NRA), .ITER(IT)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_row(in_row_a), .cell_a(cell_a_a), .cell_vld(cell_vld_a), .cell_init(cell_init_a),
    .r_in(r_in_a), .r_out(r_out_a), .r_valid(r_valid_a), .r_ready(r_ready_a),
    .busy(busy_a), .done(done_a)
`ifdef QR_ROW_SCHED_PERF_EN
    , .cyc_cnt(cyc_cnt_a)
`endif
  );

  qr_row_sched #(.DATA_WIDTH(DW), .N_COL(NCB), .N_ROW(NRB), .ITER(IT)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_row(in_row_b), .cell_a(cell_a_b), .cell_vld(cell_vld_b), .cell_init(cell_init_b),
    .r_in(r_in_b), .r_out(r_out_b), .r_valid(r_valid_b), .r_ready(r_ready_b),
    .busy(busy_b), .done(done_b)
`ifdef QR_ROW_SCHED_PERF_EN
    , .cyc_cnt(cyc_cnt_b)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- timeline model for u_b ----------------
  typedef struct {
    int              c;
    logic [DW-1:0]   d;
    bit              ini;
  } strb_t;

  strb_t             sq [NCB][$];
  logic [DW-1:0]     hold_d [NCB];
  bit                m_busy;
  int                m_next_rdy, m_rows, m_rv_cyc, m_done_cyc;
  logic [NCB*DW-1:0] m_rout, m_rout_stash;
  bit                host_pend;
  int                dut_acc[$];
  int                n_done_b = 0;

  task automatic model_reset();
    for (int j = 0; j < NCB; j++) begin
      sq[j].delete();
      hold_d[j] = '0;
    end
    m_busy     = 1'b0;
    m_next_rdy = 0;
    m_rows     = 0;
    m_rv_cyc   = -1;
    m_done_cyc = -1;
    m_rout     = '0;
    m_rout_stash = '0;
    host_pend  = 1'b0;
  endtask

  // one cycle on u_b: predict, compare, drive, advance model
  task automatic step_b(input int pv, input int ps, input int prr, input bit do_rst);
    logic [NCB-1:0]    e_vld, e_ini;
    logic [NCB*DW-1:0] e_a;
    logic              e_rdy, e_rv, e_done;
    logic [BW-1:0]     act, exp;

    if (m_rv_cyc >= 0 && cyc == m_rv_cyc) m_rout = m_rout_stash;
    for (int j = 0; j < NCB; j++) begin
      e_vld[j] = 1'b0;
      e_ini[j] = 1'b0;
      if (sq[j].size() > 0 && sq[j][0].c == cyc) begin
        e_vld[j]  = 1'b1;
        e_ini[j]  = sq[j][0].ini;
        hold_d[j] = sq[j][0].d;
        void'(sq[j].pop_front());
      end
      e_a[j*DW +: DW] = hold_d[j];
    end
    e_rdy  = m_busy && (m_rows < NRB) && (cyc >= m_next_rdy);
    e_rv   = m_busy && (m_rv_cyc >= 0) && (cyc >= m_rv_cyc);
    e_done = (cyc == m_done_cyc);
    act = {in_ready_b, busy_b, r_valid_b, done_b, cell_vld_b, cell_init_b, cell_a_b, r_out_b};
    exp = {e_rdy, m_busy, e_rv, e_done, e_vld, e_ini, e_a, m_rout};
    chk("b_cycle", 256'(act), 256'(exp));
    if (done_b) n_done_b++;

    if (do_rst) begin
      rst        = 1'b1;
      start_b    = 1'b0;
      in_valid_b = 1'b0;
      r_ready_b  = 1'b0;
      model_reset();
    end else begin
      rst     = 1'b0;
      start_b = ($urandom_range(99) < ps);
      if (!host_pend && ($urandom_range(99) < pv)) begin
        host_pend = 1'b1;
        for (int j = 0; j < NCB; j++) in_row_b[j*DW +: DW] = DW'($urandom);
      end
      in_valid_b = host_pend;
      r_ready_b  = ($urandom_range(99) < prr);
      for (int j = 0; j < NCB; j++) r_in_b[j*DW +: DW] = DW'($urandom);
      if (in_valid_b && in_ready_b) dut_acc.push_back(cyc);

      if (!m_busy) begin
        if (start_b) begin
          m_busy     = 1'b1;
          m_next_rdy = cyc + 1;
          m_rows     = 0;
          m_rv_cyc   = -1;
        end
      end else begin
        if (e_rdy && in_valid_b) begin
          for (int j = 0; j < NCB; j++)
            sq[j].push_back('{c: cyc + 1 + j, d: in_row_b[j*DW +: DW], ini: (m_rows == 0)});
          m_next_rdy = cyc + IT;
          m_rows++;
          host_pend = 1'b0;
          if (m_rows == NRB) m_rv_cyc = cyc + NCB + IT + 1;
        end
        if (m_rv_cyc >= 0 && cyc == m_rv_cyc - 1) m_rout_stash = r_in_b;
        if (e_rv && r_ready_b) begin
          m_busy     = 1'b0;
          m_done_cyc = cyc + 1;
        end
      end
    end
    tick();
  endtask

  // ---------------- directed table for u_a ----------------
  typedef struct {
    int         off;
    logic [7:0] exp;  // {in_ready, cell_vld[1:0], cell_init[1:0], r_valid, busy, done}
  } avec_t;

  avec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCA*DW-1:0] k2;
    int                t0, rv_at, n_s0;

    tbl.push_back('{0,  8'b1_00_00_010});
    tbl.push_back('{1,  8'b0_01_01_010});
    tbl.push_back('{2,  8'b0_10_10_010});
    tbl.push_back('{3,  8'b0_00_00_010});
    tbl.push_back('{12, 8'b0_00_00_010});
    tbl.push_back('{14, 8'b0_00_00_010});
    tbl.push_back('{15, 8'b0_00_00_110});
    tbl.push_back('{16, 8'b0_00_00_001});
    tbl.push_back('{17, 8'b0_00_00_000});

    rst = 1'b1;
    start_a = 0; in_valid_a = 0; r_ready_a = 0; in_row_a = '0; r_in_a = '0;
    start_b = 0; in_valid_b = 0; r_ready_b = 0; in_row_b = '0; r_in_b = '0;
    model_reset();
    tick(); tick();
    chk("a_reset", 256'({in_ready_a, cell_vld_a, cell_init_a, r_valid_a, busy_a, done_a, cell_a_a, r_out_a}), 256'(0));
    rst = 1'b0;
    tick();

    // worked example: start at s, row accepted at t = s+1
    start_a = 1'b1;
    tick();
    start_a  = 1'b0;
    t0       = cyc;
    r_ready_a = 1'b1;
    r_in_a   = {20'h12345, 20'h0ABCD};
    in_row_a = {20'hFAC00, 20'h02400};
    for (int off = 0; off <= 17; off++) begin
      in_valid_a = (off == 0);
      foreach (tbl[i]) begin
        if (tbl[i].off == off)
          chk($sformatf("a_ctl_t%0d", off),
              256'({in_ready_a, cell_vld_a, cell_init_a, r_valid_a, busy_a, done_a}),
              256'(tbl[i].exp));
      end
      if (off == 1) chk("a_col0_t1", 256'(cell_a_a[DW-1:0]), 256'(20'h02400));
      if (off == 2) chk("a_cols_t2", 256'(cell_a_a), 256'({20'hFAC00, 20'h02400}));
      if (off == 15) chk("a_rout_t15", 256'(r_out_a), 256'({20'h12345, 20'h0ABCD}));
`ifdef QR_ROW_SCHED_PERF_EN
      if (off == 16) chk("a_cyc_cnt_done", 256'(cyc_cnt_a), 256'(17));
`endif
      tick();
    end

    // result held while r_ready low; start pulses ignored in FEED and OUT
    r_ready_a = 1'b0;
    k2        = {20'h00ABC, 20'h7F001};
    r_in_a    = k2;
    start_a   = 1'b1;
    tick();
    t0         = cyc;            // start_a still high here: FEED, ignored
    in_valid_a = 1'b1;
    in_row_a   = {20'h00400, 20'hFFC00};
`ifdef QR_ROW_SCHED_PERF_EN
    chk("a2_cyc_cnt_clear", 256'(cyc_cnt_a), 256'(1));
`endif
    tick();
    start_a = 1'b0;              // in_valid_a stays high: must not be consumed again
    n_s0 = 0;
    for (int i = 0; i < 40 && !r_valid_a; i++) begin
      n_s0 += int'(cell_vld_a[0]);
      tick();
    end
    chk("a2_rvalid_seen", 256'(r_valid_a), 256'(1));
    rv_at = cyc;
    chk("a2_rvalid_time", 256'(rv_at - t0), 256'(15));
    chk("a2_single_row", 256'(n_s0), 256'(1));
    for (int h = 0; h < 20; h++) begin
      chk("a2_hold", 256'({r_valid_a, busy_a, done_a, r_out_a}), 256'({1'b1, 1'b1, 1'b0, k2}));
      r_in_a  = {DW'($urandom), DW'($urandom)};
      start_a = (h == 5);
      tick();
    end
    start_a   = 1'b0;
    r_ready_a = 1'b1;
    tick();
    r_ready_a  = 1'b0;
    in_valid_a = 1'b0;
    chk("a2_done", 256'({done_a, busy_a, r_valid_a}), 256'(3'b100));
    tick();
    chk("a2_done_once", 256'({done_a, busy_a}), 256'(2'b00));

    // u_b: held valid, check row period, then reset with row 3 pending
    step_b(100, 100, 0, 1'b0);
    dut_acc.delete();
    for (int i = 0; i < 200 && m_rows < 3; i++) step_b(100, 0, 0, 1'b0);
    step_b(100, 0, 0, 1'b0);
    step_b(100, 0, 0, 1'b0);
    chk("b_rows_before_rst", 256'(m_rows), 256'(3));
    if (dut_acc.size() >= 3) begin
      chk("b_row_period_1", 256'(dut_acc[1] - dut_acc[0]), 256'(IT));
      chk("b_row_period_2", 256'(dut_acc[2] - dut_acc[1]), 256'(IT));
    end else begin
      chk("b_accepts_seen", 256'(dut_acc.size()), 256'(3));
    end
    n_done_b = 0;
    step_b(0, 0, 0, 1'b1);
    for (int i = 0; i < 30; i++) step_b(0, 0, 50, 1'b0);
    chk("b_no_done_after_rst", 256'(n_done_b), 256'(0));

    // u_b: random traffic
    for (int i = 0; i < 3000; i++) step_b(50, 15, 40, 1'b0);
    chk("b_done_seen", 256'(n_done_b > 0), 256'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
